// File: rtl/execute_arbiter_if.sv
// execute_arbiter_if: requester, execute-stage and response signals of execute_arbiter.
// Flags ports exist only when EXEC_ARB_FLAGS_EN is defined.
interface execute_arbiter_if #(
    parameter int vecSize = 4,
    parameter int regSize = 8
);
    localparam int W = vecSize * regSize;
    logic         req0_valid, req0_ready;
    logic [2:0]   req0_op;
    logic [W-1:0] req0_vect1, req0_vect2;
    logic         req1_valid, req1_ready;
    logic [2:0]   req1_op;
    logic [W-1:0] req1_vect1, req1_vect2;
    logic [2:0]   exe_op;
    logic [W-1:0] exe_vect1, exe_vect2, exe_vect_out;
    logic         rsp0_valid, rsp1_valid;
    logic [W-1:0] rsp_data;
`ifdef EXEC_ARB_FLAGS_EN
    logic [1:0]   flags0, flags1;
`endif
    modport slave (
        input  req0_valid, req0_op, req0_vect1, req0_vect2,
        input  req1_valid, req1_op, req1_vect1, req1_vect2, exe_vect_out,
        output req0_ready, req1_ready, exe_op, exe_vect1, exe_vect2,
        output rsp0_valid, rsp1_valid, rsp_data
`ifdef EXEC_ARB_FLAGS_EN
        , output flags0, flags1
`endif
    );
    modport master (
        output req0_valid, req0_op, req0_vect1, req0_vect2,
        output req1_valid, req1_op, req1_vect1, req1_vect2, exe_vect_out,
        input  req0_ready, req1_ready, exe_op, exe_vect1, exe_vect2,
        input  rsp0_valid, rsp1_valid, rsp_data
`ifdef EXEC_ARB_FLAGS_EN
        , input flags0, flags1
`endif
    );
endinterface

// File: rtl/execute_arbiter.sv
// execute_arbiter: round-robin share of one SIMD execute stage between two requesters.
// Optional per-requester {N,Z} result flags under EXEC_ARB_FLAGS_EN.
module execute_arbiter #(
    parameter int vecSize = 4,
    parameter int regSize = 8,
    parameter int execLat = 1
) (
    input logic clk,
    input logic rst,
    execute_arbiter_if.slave bus
);
    localparam int W = vecSize * regSize;
    logic last, g0, g1, acc;
    logic [execLat:0] tag_v, tag_id;
    // last=1 means requester 1 was served most recently, so requester 0 wins a tie
    assign g0 = !rst && bus.req0_valid && (!bus.req1_valid || last);
    assign g1 = !rst && bus.req1_valid && !g0;
    assign acc = g0 || g1;
    assign bus.req0_ready = g0;
    assign bus.req1_ready = g1;
    assign bus.rsp0_valid = !rst && tag_v[execLat] && !tag_id[execLat];
    assign bus.rsp1_valid = !rst && tag_v[execLat] && tag_id[execLat];
    assign bus.rsp_data = bus.exe_vect_out;
    // tag stage 0 sits beside the exe_* registers; stage execLat lines up with exe_vect_out
    always_ff @(posedge clk) begin
        if (rst) begin
            last <= 1'b1;
            bus.exe_op <= 3'b000;
            bus.exe_vect1 <= '0;
            bus.exe_vect2 <= '0;
            tag_v <= '0;
            tag_id <= '0;
        end else begin
            if (acc) last <= g1;
            bus.exe_op <= g0 ? bus.req0_op : g1 ? bus.req1_op : 3'b000;
            if (acc) bus.exe_vect1 <= g1 ? bus.req1_vect1 : bus.req0_vect1;
            if (acc) bus.exe_vect2 <= g1 ? bus.req1_vect2 : bus.req0_vect2;
            tag_v <= {tag_v[execLat-1:0], acc};
            tag_id <= {tag_id[execLat-1:0], g1};
        end
    end
`ifdef EXEC_ARB_FLAGS_EN
    logic neg, zero;
    always_comb begin
        neg = 1'b0;
        for (int i = 0; i < vecSize; i++) neg = neg | bus.exe_vect_out[i*regSize+regSize-1];
        zero = ~|bus.exe_vect_out[W-1:0];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.flags0 <= 2'b00;
            bus.flags1 <= 2'b00;
        end else begin
            if (bus.rsp0_valid) bus.flags0 <= {neg, zero};
            if (bus.rsp1_valid) bus.flags1 <= {neg, zero};
        end
    end
`endif
endmodule

// File: tb/tb_execute_arbiter.sv
// tb_execute_arbiter: random and directed traffic against a queue-based reference model.
// Flags are checked only when EXEC_ARB_FLAGS_EN is defined.
module tb_execute_arbiter;
    localparam int VS = 4;
    localparam int RS = 8;
    localparam int EL = 1;
    localparam int W = VS * RS;

    typedef struct {
        logic         id;
        logic [W-1:0] data;
        int           due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;
    exp_t q[$];
    logic last_m = 1'b1;
    logic acc0 = 1'b0, acc1 = 1'b0;
    logic [2:0] exp_op = 3'b000;
    logic [W-1:0] exp_v1 = '0, exp_v2 = '0;
    logic [1:0] exp_f0 = 2'b00, exp_f1 = 2'b00;
    logic [W-1:0] pipe [EL];

    execute_arbiter_if #(.vecSize(VS), .regSize(RS)) bus ();
    execute_arbiter #(.vecSize(VS), .regSize(RS), .execLat(EL)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // lane-wise execute semantics; shift amount is the low bits of the second operand lane
    function automatic logic [W-1:0] calc(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        logic [RS-1:0] x, y;
        r = '0;
        for (int i = 0; i < VS; i++) begin
            x = a[i*RS+:RS];
            y = b[i*RS+:RS];
            case (op)
                3'd1: r[i*RS+:RS] = x ^ y;
                3'd2: r[i*RS+:RS] = x + y;
                3'd3: r[i*RS+:RS] = x - y;
                3'd4: r[i*RS+:RS] = x * y;
                3'd5: r[i*RS+:RS] = x >> y[2:0];
                3'd6: r[i*RS+:RS] = x << y[2:0];
                default: r[i*RS+:RS] = '0;
            endcase
        end
        return r;
    endfunction

    function automatic logic [1:0] nz(input logic [W-1:0] d);
        logic n;
        n = 1'b0;
        for (int i = 0; i < VS; i++) n = n | d[i*RS+RS-1];
        return {n, d == '0};
    endfunction

    // execute stage stand-in with EL cycles of latency
    always @(posedge clk) begin
        pipe[0] <= calc(bus.exe_op, bus.exe_vect1, bus.exe_vect2);
        for (int i = 1; i < EL; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.exe_vect_out = pipe[EL-1];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %0h, expected %0h", name, cyc, act, req);
        end
    endtask

    // monitor and reference model: grant rule, issue-order responses, NOP fill
    always @(negedge clk) begin
        exp_t e;
        logic g0, g1;
        chk("exe_op", {61'd0, bus.exe_op}, {61'd0, exp_op});
        chk("exe_vect1", {32'd0, bus.exe_vect1}, {32'd0, exp_v1});
        chk("exe_vect2", {32'd0, bus.exe_vect2}, {32'd0, exp_v2});
`ifdef EXEC_ARB_FLAGS_EN
        chk("flags0", {62'd0, bus.flags0}, {62'd0, exp_f0});
        chk("flags1", {62'd0, bus.flags1}, {62'd0, exp_f1});
`endif
        if (rst) begin
            chk("ready_rst", {62'd0, bus.req1_ready, bus.req0_ready}, 64'd0);
            chk("rsp_rst", {62'd0, bus.rsp1_valid, bus.rsp0_valid}, 64'd0);
            q.delete();
            last_m = 1'b1;
            acc0 = 1'b0;
            acc1 = 1'b0;
            exp_op = 3'b000;
            exp_v1 = '0;
            exp_v2 = '0;
            exp_f0 = 2'b00;
            exp_f1 = 2'b00;
        end else begin
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                chk("rsp_valid", {62'd0, bus.rsp1_valid, bus.rsp0_valid}, e.id ? 64'd2 : 64'd1);
                chk("rsp_data", {32'd0, bus.rsp_data}, {32'd0, e.data});
                if (e.id) exp_f1 = nz(e.data);
                else exp_f0 = nz(e.data);
            end else begin
                chk("rsp_idle", {62'd0, bus.rsp1_valid, bus.rsp0_valid}, 64'd0);
            end
            g0 = bus.req0_valid && (!bus.req1_valid || last_m);
            g1 = bus.req1_valid && !g0;
            chk("ready", {62'd0, bus.req1_ready, bus.req0_ready}, {62'd0, g1, g0});
            acc0 = g0;
            acc1 = g1;
            exp_op = 3'b000;
            if (g0 || g1) begin
                last_m = g1;
                exp_op = g1 ? bus.req1_op : bus.req0_op;
                exp_v1 = g1 ? bus.req1_vect1 : bus.req0_vect1;
                exp_v2 = g1 ? bus.req1_vect2 : bus.req0_vect2;
                e.id = g1;
                e.data = calc(exp_op, exp_v1, exp_v2);
                e.due = cyc + EL + 1;
                q.push_back(e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (acc0) bus.req0_valid = 1'b0;
        if (acc1) bus.req1_valid = 1'b0;
    endtask

    task automatic set_req(input int id, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        if (id == 0) begin
            bus.req0_valid = 1'b1;
            bus.req0_op = op;
            bus.req0_vect1 = a;
            bus.req0_vect2 = b;
        end else begin
            bus.req1_valid = 1'b1;
            bus.req1_op = op;
            bus.req1_vect1 = a;
            bus.req1_vect2 = b;
        end
    endtask

    initial begin
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req0_op = 3'd0;
        bus.req1_op = 3'd0;
        bus.req0_vect1 = '0;
        bus.req0_vect2 = '0;
        bus.req1_vect1 = '0;
        bus.req1_vect2 = '0;
        repeat (3) tick();
        rst = 1'b0;
        set_req(0, 3'd2, 32'h33, 32'h0F);
        repeat (4) tick();
        set_req(0, 3'd1, 32'h33, 32'h0F);
        set_req(1, 3'd3, 32'h0000_5050, 32'h0000_1020);
        repeat (4) tick();
        repeat (8) begin
            if (!bus.req0_valid) set_req(0, 3'($urandom_range(1, 6)), $urandom, $urandom);
            if (!bus.req1_valid) set_req(1, 3'($urandom_range(1, 6)), $urandom, $urandom);
            tick();
        end
        repeat (2) tick();
        repeat (3) tick();
        set_req(1, 3'd4, 32'h0305_0709, 32'h0202_0202);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        set_req(0, 3'd3, 32'h1234_5678, 32'h1234_5678);
        tick();
        set_req(1, 3'd3, 32'h0000_CC00, 32'h0000_F000);
        repeat (4) tick();
        repeat (400) begin
            if (!bus.req0_valid && ($urandom % 3 != 0)) set_req(0, 3'($urandom % 8), $urandom, $urandom);
            if (!bus.req1_valid && ($urandom % 3 != 0)) set_req(1, 3'($urandom % 8), $urandom, $urandom);
            rst = ($urandom % 50 == 0);
            tick();
        end
        rst = 1'b0;
        repeat (10) tick();
        chk("drain", 64'(q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
